// File: rtl/skolem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : skolem_sweep_ctrl
// Description : Exhaustive-check sequencer for a candidate Skolem netlist.
//               It drives all 2^N_IN universal-input assignments, one per
//               cycle. Each assignment is checked against an external
//               specification bit, with the netlist latency LAT absorbed by
//               an alignment shift register. The block counts failures and
//               captures the first counterexample.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start             - begin a sweep (accepted only in IDLE)
//               stop_on_fail      - latched with start; end at first failure
//               x_out             - assignment driven to the netlist
//               y_in, spec_ok     - netlist outputs / spec result, LAT late
//               busy, done        - sweep in progress / results-final pulse
//               pass, fail_cnt    - verdict and failure count of last sweep
//               first_x, first_y  - first counterexample
//               first_vld         - first_x/first_y hold a captured failure
// Revision    : 1.0 - initial release
// ============================================================================
module skolem_sweep_ctrl #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 2,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_fail,
    output logic [N_IN-1:0]  x_out,
    input  logic [N_OUT-1:0] y_in,
    input  logic             spec_ok,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    fail_cnt,
    output logic [N_IN-1:0]  first_x,
    output logic [N_OUT-1:0] first_y,
    output logic             first_vld
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_IN-1:0] r_cnt;
    logic            r_stop;

    logic            w_issue;
    logic            w_accept;
    logic            w_cnt_last;
    logic            w_al_vld;
    logic [N_IN-1:0] w_al_x;
    logic            w_drain_last;
    logic            w_fail;

    assign w_issue    = (r_state == S_SWEEP);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_cnt_last = (r_cnt == {N_IN{1'b1}});

    // Checks are only meaningful while issues can still be in flight; once in
    // DONE (e.g. after an early stop) anything left in the pipe is discarded.
    assign w_fail = w_al_vld && !spec_ok &&
                    ((r_state == S_SWEEP) || (r_state == S_DRAIN));

    generate
        if (LAT == 0) begin : g_comb
            // Combinational netlist: the issue is checked in its own cycle.
            assign w_al_vld     = w_issue;
            assign w_al_x       = r_cnt;
            assign w_drain_last = 1'b1;
        end else begin : g_pipe
            localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

            logic [LAT-1:0]  r_vld;
            logic [N_IN-1:0] r_xs [LAT];
            logic [DW-1:0]   r_drain;

            // Alignment register: tag each issue with its x so the check
            // LAT cycles later knows which assignment the result belongs to.
            // Cleared on start so leftovers of an early-stopped sweep never
            // leak into the next one.
            always_ff @(posedge clk) begin
                if (rst || w_accept) begin
                    r_vld <= '0;
                    for (int i = 0; i < LAT; i++) r_xs[i] <= '0;
                end else begin
                    r_vld[0] <= w_issue;
                    r_xs[0]  <= w_issue ? r_cnt : '0;
                    for (int i = 1; i < LAT; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_xs[i]  <= r_xs[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst || (r_state != S_DRAIN)) r_drain <= '0;
                else                             r_drain <= r_drain + 1'b1;
            end

            assign w_al_vld     = r_vld[LAT-1];
            assign w_al_x       = r_xs[LAT-1];
            assign w_drain_last = (r_drain == DW'(LAT - 1));
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                if (w_fail && r_stop) w_state_nxt = S_DONE;
                else if (w_cnt_last)  w_state_nxt = (LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if ((w_fail && r_stop) || w_drain_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_stop    <= 1'b0;
            pass      <= 1'b0;
            fail_cnt  <= '0;
            first_x   <= '0;
            first_y   <= '0;
            first_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt     <= '0;
                r_stop    <= stop_on_fail;
                pass      <= 1'b0;
                fail_cnt  <= '0;
                first_x   <= '0;
                first_y   <= '0;
                first_vld <= 1'b0;
            end else begin
                if (w_issue) r_cnt <= r_cnt + 1'b1;
                if (w_fail) begin
                    fail_cnt <= fail_cnt + 1'b1;
                    if (!first_vld) begin
                        first_x   <= w_al_x;
                        first_y   <= y_in;
                        first_vld <= 1'b1;
                    end
                end
                // Verdict is formed on the way into DONE so it already
                // reflects a failure checked in the final checking cycle.
                if (w_state_nxt == S_DONE) pass <= (fail_cnt == '0) && !w_fail;
            end
        end
    end

    assign x_out = (r_state == S_SWEEP) ? r_cnt : '0;
    assign busy  = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/skolem_sweep_ctrl.md
# skolem_sweep_ctrl

Exhaustive-check sequencer for a synthesized Skolem function netlist. On `start` it drives every one of the 2^N_IN input assignments onto the netlist's universal inputs, one per cycle. It checks an externally evaluated specification bit for each assignment, accounting for the netlist's pipeline latency. It counts failures and captures the first counterexample. It sits between a candidate Skolem netlist (inputs i0.., outputs i5.. style) and a combinational specification evaluator in the on-chip validation harness.

## Interface
Parameters:
- N_IN, 5, number of universal inputs driven to the netlist
- N_OUT, 2, number of Skolem outputs returned by the netlist
- LAT, 0, netlist latency in cycles from `x_out` to `y_in`/`spec_ok` (0 = combinational)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- stop_on_fail  in  1  sampled with `start`; 1 = end the sweep at the first failure
- x_out  out  N_IN  assignment driven to the netlist inputs
- y_in  in  N_OUT  netlist outputs, valid LAT cycles after the matching `x_out`
- spec_ok  in  1  specification F(x,y) result for the aligned (x, y_in); 1 = holds
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  one-cycle pulse when results are final
- pass  out  1  1 if the last completed sweep saw zero failures
- fail_cnt  out  N_IN+1  failures counted in the last sweep
- first_x  out  N_IN  assignment of the first failure
- first_y  out  N_OUT  netlist outputs at the first failure
- first_vld  out  1  first_x/first_y hold a captured failure

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE, with `start` high:
  - latch `stop_on_fail`
  - clear fail_cnt, first_vld, pass, first_x, first_y
  - set x counter to 0
  - go to SWEEP
- SWEEP issues one assignment per cycle. `x_out` = counter, counter +1 each cycle, 0 through 2^N_IN−1.
- Issue tagging: each issue pushes (valid=1, x) into a LAT-deep alignment shift register. With LAT=0 the issue is checked in the same cycle.
- Check: when the aligned valid is 1 and `spec_ok`=0:
  - fail_cnt +1
  - if first_vld=0, capture first_x = aligned x, first_y = `y_in`, and set first_vld=1
- After issuing 2^N_IN−1:
  - LAT=0: go to DONE
  - LAT>0: go to DRAIN. DRAIN keeps checking but issues nothing; valid=0 is shifted in. Stay LAT cycles, then go to DONE.
- stop_on_fail=1 and a failure is checked (SWEEP or DRAIN): go to DONE next cycle. Issuing stops. Results still in flight are discarded, so fail_cnt=1.
- DONE: `done`=1 for one cycle, pass = (fail_cnt==0), then go to IDLE.
- Results (pass, fail_cnt, first_*) hold until the next accepted `start` or `rst`.
- `start` outside IDLE is ignored.
- `x_out` is 0 whenever not in SWEEP.
- Arithmetic: fail_cnt is N_IN+1 bits and can reach 2^N_IN without wrap. The issue counter needs no wrap detection beyond comparing to the all-ones value.

## Timing
- Reset values: x_out=0, busy=0, done=0, pass=0, fail_cnt=0, first_x=0, first_y=0, first_vld=0. State = IDLE and the alignment register is cleared.
- `rst` mid-sweep: the next cycle is IDLE with all reset values. No `done` pulse.
- For a full sweep with `start` sampled at cycle 0:
  - busy is high from cycle 1 through cycle 2^N_IN+LAT
  - x_out = k at cycle 1+k
  - the check for k occurs at cycle 1+k+LAT
  - done is at cycle 2^N_IN+LAT+1
- Early stop: with a failure checked at cycle c, done is at c+1 and busy drops at c+1.
- `start` is accepted on the same cycle `done` drops, i.e. the cycle after DONE at the earliest.

## Test plan
- Correct candidate, LAT=0, N_IN=5: pulse start at cycle 0 -> x_out walks 0..31 over cycles 1..32, done at cycle 33, pass=1, fail_cnt=0, first_vld=0.
- Bench forces spec_ok=0 at x=19 and x=27 with y_in=2'b10 at x=19, stop_on_fail=0 -> fail_cnt=2, first_x=19, first_y=2'b10, first_vld=1, pass=0, done at cycle 33.
- stop_on_fail=1, failure at x=7 (LAT=0, checked at cycle 8) -> done at cycle 9, fail_cnt=1, first_x=7, busy low from cycle 9, x_out=0.
- LAT=2 registered netlist model, failure at x=31 only -> x_out=31 at cycle 32, DRAIN at cycles 33–34, done at cycle 35, first_x=31 (the alignment is correct, not x=29).
- rst asserted at the cycle x_out=10 -> next cycle busy=0, fail_cnt=0, no done. A start during SWEEP in a later run is ignored (x_out sequence undisturbed). A fresh start after rst completes a normal sweep.
